// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester mmu port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker. Owner encoding follows
// arb_owner_e: 0 = instruction port, 1 = data port.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic instr_req,
  input  logic data_req,
  input  logic last_owner,
  output logic winner,
  output logic valid
);

  // A lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    valid  = instr_req | data_req;
    winner = logic'(OWNER_INSTR);
    if (instr_req && data_req) begin
      winner = (last_owner == logic'(OWNER_DATA)) ? logic'(OWNER_INSTR) : logic'(OWNER_DATA);
    end else if (data_req) begin
      winner = logic'(OWNER_DATA);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mmu request/response port between the instruction-fetch and
// data ports. One transaction in flight, round-robin on ties, and a bounded
// wait that turns a missing response into an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [MEM_ADDR_W-1:0] instr_addr_i,
  input  logic                  instr_we_i,
  input  logic [MEM_BE_W-1:0]   instr_be_i,
  input  logic [MEM_DATA_W-1:0] instr_wdata_i,
  output logic                  instr_rvalid_o,
  output logic                  instr_err_o,
  output logic [MEM_DATA_W-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [MEM_ADDR_W-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [MEM_BE_W-1:0]   data_be_i,
  input  logic [MEM_DATA_W-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic                  data_err_o,
  output logic [MEM_DATA_W-1:0] data_rdata_o,
  output logic                  mmu_req_o,
  output logic [MEM_ADDR_W-1:0] mmu_addr_o,
  output logic                  mmu_we_o,
  output logic [MEM_BE_W-1:0]   mmu_be_o,
  output logic [MEM_DATA_W-1:0] mmu_wdata_o,
  input  logic                  mmu_rvalid_i,
  input  logic                  mmu_err_i,
  input  logic [MEM_DATA_W-1:0] mmu_rdata_i,
  output logic                  busy_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_reg, state_next;
  arb_owner_e            last_owner_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic [MEM_DATA_W-1:0] rsp_rdata_reg;
  logic [MEM_ADDR_W-1:0] mmu_addr_reg;
  logic                  mmu_we_reg;
  logic [MEM_BE_W-1:0]   mmu_be_reg;
  logic [MEM_DATA_W-1:0] mmu_wdata_reg;

  logic       pick_winner;
  logic       pick_valid;
  logic       grant;
  logic       timeout_hit;
  arb_owner_e win_owner;

  mem_arb_rr_pick u_pick (
    .instr_req  (instr_req_i),
    .data_req   (data_req_i),
    .last_owner (logic'(last_owner_reg)),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign win_owner   = arb_owner_e'(pick_winner);
  assign timeout_hit = (state_reg == ARB_WAIT) && !mmu_rvalid_i && (cnt_reg == CNT_LAST);

  // Next-state logic; a grant is only possible from IDLE and never during reset.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid && !rst) begin
          grant      = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_next = ARB_WAIT;
      ARB_WAIT: begin
        if (mmu_rvalid_i || timeout_hit) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State, payload capture, wait counter and the one-cycle response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      last_owner_reg <= OWNER_DATA;
      cnt_reg        <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_rdata_reg  <= '0;
      mmu_addr_reg   <= '0;
      mmu_we_reg     <= 1'b0;
      mmu_be_reg     <= '0;
      mmu_wdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      if (grant) begin
        last_owner_reg <= win_owner;
        if (win_owner == OWNER_DATA) begin
          mmu_addr_reg  <= data_addr_i;
          mmu_we_reg    <= data_we_i;
          mmu_be_reg    <= data_be_i;
          mmu_wdata_reg <= data_wdata_i;
        end else begin
          mmu_addr_reg  <= instr_addr_i;
          mmu_we_reg    <= instr_we_i;
          mmu_be_reg    <= instr_be_i;
          mmu_wdata_reg <= instr_wdata_i;
        end
      end
      if (state_reg == ARB_ISSUE) begin
        cnt_reg <= '0;
      end
      if (state_reg == ARB_WAIT) begin
        if (mmu_rvalid_i) begin
          // A real response beats a timeout landing in the same cycle.
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= mmu_err_i;
          rsp_rdata_reg <= mmu_rdata_i;
        end else if (timeout_hit) begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // The response register is steered to whichever port owned the transaction;
  // last_owner_reg cannot change before the response cycle has been seen.
  assign instr_rvalid_o = rsp_valid_reg && (last_owner_reg == OWNER_INSTR);
  assign data_rvalid_o  = rsp_valid_reg && (last_owner_reg == OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o & rsp_err_reg;
  assign data_err_o     = data_rvalid_o & rsp_err_reg;
  assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata_reg : '0;
  assign data_rdata_o   = data_rvalid_o ? rsp_rdata_reg : '0;

  assign instr_gnt_o = grant && (win_owner == OWNER_INSTR);
  assign data_gnt_o  = grant && (win_owner == OWNER_DATA);

  assign mmu_req_o   = (state_reg == ARB_ISSUE);
  assign mmu_addr_o  = mmu_addr_reg;
  assign mmu_we_o    = mmu_we_reg;
  assign mmu_be_o    = mmu_be_reg;
  assign mmu_wdata_o = mmu_wdata_reg;
  assign busy_o      = (state_reg != ARB_IDLE);

endmodule
